// File: rtl/audio_i2s_tx.sv
// Stereo I2S / left-justified serial transmitter with a small pair FIFO.
// Frames are 2*SLOT_W bit clocks; the FIFO is popped once per frame start.
module audio_i2s_tx #(
    parameter int SAMPLE_W   = 16,
    parameter int SLOT_W     = 24,
    parameter int SCLK_DIV   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          CLK,
    input  logic                          reset,
    input  logic                          fmt,
    input  logic [SAMPLE_W-1:0]           in_left,
    input  logic [SAMPLE_W-1:0]           in_right,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun,
    output logic                          aud_mclk,
    output logic                          aud_sclk,
    output logic                          aud_lrck,
    output logic                          aud_sdin
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int DW = $clog2(SCLK_DIV);
    localparam int BW = $clog2(2 * SLOT_W);
    localparam int PW = 2 * SAMPLE_W;

    localparam logic [DW-1:0] D_LAST = DW'(SCLK_DIV - 1);
    localparam logic [DW-1:0] D_HALF = DW'(SCLK_DIV / 2);
    localparam logic [BW-1:0] B_LAST = BW'(2 * SLOT_W - 1);
    localparam logic [BW-1:0] B_SLOT = BW'(SLOT_W);
    localparam logic [LW-1:0] L_FULL = LW'(FIFO_DEPTH);

    logic [DW-1:0]       d;
    logic [BW-1:0]       b;
    logic                fmt_q;
    logic [SAMPLE_W-1:0] cur_l;
    logic [SAMPLE_W-1:0] cur_r;
    logic [PW-1:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [LW-1:0]       level;

    logic sclk_fall;
    logic frame_start;
    logic push;
    logic pop;

    assign sclk_fall   = (d == D_LAST);
    assign frame_start = sclk_fall && (b == B_LAST);
    assign in_ready    = !reset && (level != L_FULL);
    assign push        = in_valid && in_ready;
    assign pop         = frame_start && (level != '0);

    always_ff @(posedge CLK) begin
        if (reset) begin
            d        <= '0;
            b        <= '0;
            fmt_q    <= 1'b0;
            cur_l    <= '0;
            cur_r    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            underrun <= 1'b0;
        end else begin
            d        <= sclk_fall ? '0 : d + DW'(1);
            underrun <= frame_start && (level == '0);
            if (sclk_fall) begin
                b <= (b == B_LAST) ? '0 : b + BW'(1);
            end
            if (frame_start) begin
                fmt_q <= fmt;
            end
            // An empty FIFO at frame start keeps the previous pair playing
            if (pop) begin
                {cur_l, cur_r} <= mem[rd_ptr];
                rd_ptr         <= rd_ptr + AW'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            unique case (1'b1)
                push && !pop: level <= level + LW'(1);
                pop && !push: level <= level - LW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= {in_left, in_right};
        end
    end

    assign fifo_level = level;
    assign aud_mclk   = d[0];
    assign aud_sclk   = (d >= D_HALF);

    logic                right;
    logic [BW-1:0]       p;
    logic [BW-1:0]       b_nxt;
    logic [BW-1:0]       sh_amt;
    logic [SAMPLE_W-1:0] samp;
    logic [SAMPLE_W-1:0] shifted;

    // I2S delays data by one bit clock, so its shift is one less than LJ
    always_comb begin
        right    = (b >= B_SLOT);
        p        = right ? b - B_SLOT : b;
        samp     = right ? cur_r : cur_l;
        b_nxt    = (b == B_LAST) ? '0 : b + BW'(1);
        sh_amt   = fmt_q ? p : p - BW'(1);
        shifted  = samp << sh_amt;
        aud_lrck = fmt_q ? right : (b_nxt >= B_SLOT);
        aud_sdin = (fmt_q || (p != '0)) && shifted[SAMPLE_W-1];
    end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Randomized bench for audio_i2s_tx against a cycle-count reference model.
// Covers the default build and a 24-bit / 32-slot / div-8 build.
module tb_audio_i2s_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        fmt;
    logic [15:0] l0, r0;
    logic        v0;
    logic        rdy0, und0, mclk0, sclk0, lrck0, sdin0;
    logic [2:0]  lvl0;
    logic [23:0] l1, r1;
    logic        v1;
    logic        rdy1, und1, mclk1, sclk1, lrck1, sdin1;
    logic [2:0]  lvl1;

    audio_i2s_tx dut0 (
        .CLK(clk), .reset(reset), .fmt(fmt),
        .in_left(l0), .in_right(r0), .in_valid(v0),
        .in_ready(rdy0), .fifo_level(lvl0), .underrun(und0),
        .aud_mclk(mclk0), .aud_sclk(sclk0),
        .aud_lrck(lrck0), .aud_sdin(sdin0)
    );

    audio_i2s_tx #(
        .SAMPLE_W(24), .SLOT_W(32), .SCLK_DIV(8), .FIFO_DEPTH(4)
    ) dut1 (
        .CLK(clk), .reset(reset), .fmt(fmt),
        .in_left(l1), .in_right(r1), .in_valid(v1),
        .in_ready(rdy1), .fifo_level(lvl1), .underrun(und1),
        .aud_mclk(mclk1), .aud_sclk(sclk1),
        .aud_lrck(lrck1), .aud_sdin(sdin1)
    );

    int n_cmp = 0;
    int n_fail = 0;

    bit wide;
    int DIV, S, SW, DEP, FR;
    int k;
    int unsigned ql[$], qr[$];
    int unsigned cur_l, cur_r;
    bit fmt_m, und_m;
    bit drv_v;
    int unsigned drv_l, drv_r;
    logic [63:0] cap_sd, cap_lr;
    int cap_f;
    int und_cnt;
    int und_k[$];

    task automatic set_mode(input bit w);
        wide = w;
        DIV  = w ? 8 : 16;
        S    = w ? 32 : 24;
        SW   = w ? 24 : 16;
        DEP  = 4;
        FR   = 2 * S * DIV;
    endtask

    function automatic int unsigned msk(input int unsigned x);
        return (SW == 24) ? (x & 32'h00FF_FFFF) : (x & 32'h0000_FFFF);
    endfunction

    task automatic tick();
        int d, b, p;
        int unsigned samp;
        bit e_sd, e_lr, rdy;
        logic [8:0] got, exp;
        logic o_sd, o_lr, o_und;
        v0 = !wide && drv_v;
        l0 = 16'(drv_l);
        r0 = 16'(drv_r);
        v1 = wide && drv_v;
        l1 = 24'(drv_l);
        r1 = 24'(drv_r);
        d = k % DIV;
        b = (k / DIV) % (2 * S);
        p = b % S;
        samp = (b < S) ? cur_l : cur_r;
        if (fmt_m) begin
            e_sd = (p < SW) ? 1'((samp >> (SW - 1 - p)) & 1) : 1'b0;
            e_lr = (b >= S);
        end else begin
            e_sd = (p >= 1 && p <= SW) ? 1'((samp >> (SW - p)) & 1) : 1'b0;
            e_lr = (((b + 1) % (2 * S)) >= S);
        end
        exp = {1'(d % 2), 1'(d >= DIV / 2), e_lr, e_sd, und_m,
               1'(ql.size() < DEP), 3'(ql.size())};
        if (wide) begin
            got = {mclk1, sclk1, lrck1, sdin1, und1, rdy1, lvl1};
            o_sd = sdin1; o_lr = lrck1; o_und = und1;
        end else begin
            got = {mclk0, sclk0, lrck0, sdin0, und0, rdy0, lvl0};
            o_sd = sdin0; o_lr = lrck0; o_und = und0;
        end
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL stream k=%0d got=%b want=%b (mclk,sclk,lrck,sdin,und,rdy,lvl)",
                     k, got, exp);
        end
        if ((k / FR) == cap_f && d == DIV / 2) begin
            cap_sd = {cap_sd[62:0], o_sd};
            cap_lr = {cap_lr[62:0], o_lr};
        end
        if (o_und === 1'b1) begin
            und_cnt++;
            und_k.push_back(k);
        end
        rdy = (ql.size() < DEP);
        und_m = 1'b0;
        if ((k % FR) == FR - 1) begin
            fmt_m = fmt;
            if (ql.size() > 0) begin
                cur_l = ql.pop_front();
                cur_r = qr.pop_front();
            end else begin
                und_m = 1'b1;
            end
        end
        if (drv_v && rdy) begin
            ql.push_back(msk(drv_l));
            qr.push_back(msk(drv_r));
        end
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic do_reset();
        logic [8:0] got;
        reset = 1'b1;
        drv_v = 1'b0;
        v0 = 1'b0;
        v1 = 1'b0;
        @(posedge clk);
        #1;
        got = wide ? {mclk1, sclk1, lrck1, sdin1, und1, rdy1, lvl1}
                   : {mclk0, sclk0, lrck0, sdin0, und0, rdy0, lvl0};
        n_cmp++;
        if (got !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_out got=%b want=%b", got, 9'b0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        k = 0;
        ql.delete();
        qr.delete();
        cur_l = 0;
        cur_r = 0;
        fmt_m = 1'b0;
        und_m = 1'b0;
        und_cnt = 0;
        und_k.delete();
        cap_f = -1;
        cap_sd = '0;
        cap_lr = '0;
        #1;
        n_cmp++;
        if ((wide ? rdy1 : rdy0) !== 1'b1) begin
            n_fail++;
            $display("FAIL release_ready got=%b want=1", wide ? rdy1 : rdy0);
        end
    endtask

    task automatic push_one(input int unsigned l, input int unsigned r);
        drv_v = 1'b1;
        drv_l = l;
        drv_r = r;
        tick();
        drv_v = 1'b0;
    endtask

    task automatic test_reset();
        set_mode(0);
        fmt = 1'b0;
        do_reset();
        repeat (40) tick();
    endtask

    task automatic test_lj();
        set_mode(0);
        fmt = 1'b1;
        do_reset();
        cap_f = 1;
        push_one(32'hA5C3, 32'h0F0F);
        repeat (3 * FR - 1) tick();
        n_cmp++;
        if (cap_sd[47:0] !== 48'hA5C300_0F0F00) begin
            n_fail++;
            $display("FAIL lj_data got=%h want=%h", cap_sd[47:0], 48'hA5C300_0F0F00);
        end
        n_cmp++;
        if (cap_lr[47:0] !== 48'h000000_FFFFFF) begin
            n_fail++;
            $display("FAIL lj_lrck got=%h want=%h", cap_lr[47:0], 48'h000000_FFFFFF);
        end
        n_cmp++;
        if (und_cnt !== 1) begin
            n_fail++;
            $display("FAIL lj_underrun got=%0d want=1", und_cnt);
        end
    endtask

    task automatic test_i2s();
        set_mode(0);
        fmt = 1'b0;
        do_reset();
        cap_f = 1;
        push_one(32'hA5C3, 32'h0F0F);
        repeat (2 * FR) tick();
        n_cmp++;
        if (cap_sd[47:0] !== 48'h52E180_078780) begin
            n_fail++;
            $display("FAIL i2s_data got=%h want=%h", cap_sd[47:0], 48'h52E180_078780);
        end
        n_cmp++;
        if (cap_lr[47:0] !== 48'h000001_FFFFFE) begin
            n_fail++;
            $display("FAIL i2s_lrck got=%h want=%h", cap_lr[47:0], 48'h000001_FFFFFE);
        end
    endtask

    task automatic test_back_to_back();
        int unsigned pl[5], pr[5];
        set_mode(0);
        fmt = 1'b0;
        do_reset();
        cap_f = 4;
        for (int i = 0; i < 5; i++) begin
            pl[i] = $urandom & 32'hFFFF;
            pr[i] = $urandom & 32'hFFFF;
        end
        for (int i = 0; i < 4; i++) push_one(pl[i], pr[i]);
        n_cmp++;
        if (rdy0 !== 1'b0 || lvl0 !== 3'd4) begin
            n_fail++;
            $display("FAIL b2b_full got rdy=%b lvl=%0d want rdy=0 lvl=4", rdy0, lvl0);
        end
        drv_v = 1'b1;
        drv_l = pl[4];
        drv_r = pr[4];
        repeat (10) tick();
        drv_v = 1'b0;
        while (k < 6 * FR) tick();
        n_cmp++;
        if (cap_sd[47:24] !== (24'(pl[3]) << 7)) begin
            n_fail++;
            $display("FAIL b2b_order got=%h want=%h", cap_sd[47:24], 24'(pl[3]) << 7);
        end
        n_cmp++;
        if (und_cnt !== 1) begin
            n_fail++;
            $display("FAIL b2b_underrun got=%0d want=1", und_cnt);
        end
    endtask

    task automatic test_underrun();
        int gap;
        set_mode(0);
        fmt = 1'b1;
        do_reset();
        push_one($urandom, $urandom);
        repeat (5 * FR - 1) tick();
        n_cmp++;
        if (und_cnt !== 3) begin
            n_fail++;
            $display("FAIL ur_count got=%0d want=3", und_cnt);
        end
        gap = (und_k.size() >= 2) ? und_k[1] - und_k[0] : -1;
        n_cmp++;
        if (gap !== 768) begin
            n_fail++;
            $display("FAIL ur_period got=%0d want=768", gap);
        end
    endtask

    task automatic test_reset_mid();
        int cnt;
        set_mode(0);
        fmt = 1'b1;
        do_reset();
        push_one($urandom, $urandom);
        push_one($urandom, $urandom);
        while (k < 30 * DIV + 5) tick();
        do_reset();
        cnt = 0;
        while (sclk0 !== 1'b1 && cnt < 100) begin
            tick();
            cnt++;
        end
        n_cmp++;
        if (cnt !== 8) begin
            n_fail++;
            $display("FAIL rst_first_sclk got=%0d want=8", cnt);
        end
        repeat (2 * FR) tick();
    endtask

    task automatic test_random();
        int burst;
        set_mode(0);
        fmt = 1'($urandom);
        do_reset();
        burst = 0;
        repeat (10 * FR) begin
            if ($urandom_range(0, 2999) == 0) burst = 6;
            drv_v = ($urandom_range(0, 499) == 0) || (burst > 0) ||
                    (((k % FR) == FR - 1) && ($urandom_range(0, 1) == 1));
            if (burst > 0) burst--;
            drv_l = $urandom;
            drv_r = $urandom;
            if ($urandom_range(0, 399) == 0) fmt = ~fmt;
            tick();
        end
        drv_v = 1'b0;
    endtask

    task automatic test_wide();
        int unsigned wl, wr;
        set_mode(1);
        for (int m = 0; m < 2; m++) begin
            fmt = (m == 0);
            do_reset();
            cap_f = 1;
            wl = $urandom & 32'hFF_FFFF;
            wr = $urandom & 32'hFF_FFFF;
            push_one(wl, wr);
            repeat (3 * FR - 1) tick();
            n_cmp++;
            if (m == 0 ? cap_sd !== {24'(wl), 8'h00, 24'(wr), 8'h00}
                       : cap_sd !== {1'b0, 24'(wl), 7'h00, 1'b0, 24'(wr), 7'h00}) begin
                n_fail++;
                $display("FAIL wide_data fmt=%0d got=%h", fmt, cap_sd);
            end
            n_cmp++;
            if (cap_lr !== (m == 0 ? 64'h00000000_FFFFFFFF : 64'h00000001_FFFFFFFE)) begin
                n_fail++;
                $display("FAIL wide_lrck fmt=%0d got=%h", fmt, cap_lr);
            end
            n_cmp++;
            if ((und_k.size() > 0 ? und_k[0] : -1) !== 1024) begin
                n_fail++;
                $display("FAIL wide_frame got=%0d want=1024",
                         und_k.size() > 0 ? und_k[0] : -1);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        fmt = 1'b0;
        v0 = 1'b0; l0 = '0; r0 = '0;
        v1 = 1'b0; l1 = '0; r1 = '0;
        drv_v = 1'b0; drv_l = 0; drv_r = 0;
        test_reset();
        test_lj();
        test_i2s();
        test_back_to_back();
        test_underrun();
        test_reset_mid();
        test_random();
        test_wide();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
